mem_interface: RTL and testbench

Memory interface stage sitting directly upstream of the 32-bit synchronous RAM (`ram2`). It holds the CPU's MAR and MDR and runs a small handshake FSM. The FSM turns single-cycle read/write requests from the control unit into correctly timed `read_enable`/`write_enable`/address/data strobes, accounting for the RAM's registered output. Read data is captured into MDR and a one-cycle done pulse tells the control unit when it may proceed.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_fsm.sv | 61 ++++++
 rtl/mem_interface.sv | 85 ++++++++
 tb/tb_mem_interface.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : shared widths and handshake state encoding for the memory stage
// Revision: 1.0
// ============================================================================
package mem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_CAPTURE = 3'd2,
    WR_ISSUE   = 3'd3,
    DONE       = 3'd4
  } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_fsm.sv
`default_nettype none
// ============================================================================
// mem_fsm : request handshake FSM driving RAM strobes, done pulse and busy
// Revision: 1.0
// ============================================================================
module mem_fsm
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       rd_req,
  input  logic       wr_req,
  output mem_state_e state,
  output logic       busy,
  output logic       mem_done,
  output logic       ram_read_enable,
  output logic       ram_write_enable
);

  mem_state_e state_q;
  mem_state_e state_d;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write wins over a simultaneous read; the read is dropped, not queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d = WR_ISSUE;
        end else if (rd_req) begin
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: state_d = DONE;
      WR_ISSUE:   state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Enables are masked by clear so an aborted transaction never reaches the RAM.
  always_comb begin
    busy             = (state_q != IDLE);
    mem_done         = (state_q == DONE);
    ram_read_enable  = (state_q == RD_ISSUE) && !clear;
    ram_write_enable = (state_q == WR_ISSUE) && !clear;
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/mem_interface.sv
`default_nettype none
// ============================================================================
// mem_interface : MAR/MDR holding registers plus handshake to registered RAM
// Revision: 1.0
// ============================================================================
module mem_interface #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  output logic              ram_read_enable,
  input  logic [DATA_W-1:0] ram_data_out
);

  import mem_pkg::*;

  logic [ADDR_W-1:0] mar_q;
  logic [ADDR_W-1:0] mar_d;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] mdr_d;
  mem_state_e        state;

  mem_fsm u_fsm (
    .clk              (clk),
    .clear            (clear),
    .rd_req           (rd_req),
    .wr_req           (wr_req),
    .state            (state),
    .busy             (busy),
    .mem_done         (mem_done),
    .ram_read_enable  (ram_read_enable),
    .ram_write_enable (ram_write_enable)
  );

  // Loads are only honoured in IDLE so the RAM sees stable MAR/MDR mid-transaction.
  always_comb begin
    mar_d = mar_q;
    mdr_d = mdr_q;
    if (state == IDLE) begin
      if (mar_in) begin
        mar_d = bus_in[ADDR_W-1:0];
      end
      if (mdr_in) begin
        mdr_d = bus_in;
      end
    end else if (state == RD_CAPTURE) begin
      mdr_d = ram_data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      mar_q <= mar_d;
      mdr_q <= mdr_d;
    end
  end

  generate
    if (DATA_W > ADDR_W) begin : g_bus_hi
      logic unused_bus_hi;
      assign unused_bus_hi = ^bus_in[DATA_W-1:ADDR_W];
    end
  endgenerate

  assign mdr_out     = mdr_q;
  assign ram_address = mar_q;
  assign ram_data_in = mdr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_interface.sv
`default_nettype none
// ============================================================================
// tb_mem_interface : scoreboard bench with behavioural RAM and transaction model
// Revision: 1.0
// ============================================================================
module tb_mem_interface;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          clear;
  logic [DW-1:0] bus_in;
  logic          mar_in, mdr_in, rd_req, wr_req;
  logic [DW-1:0] mdr_out;
  logic          busy, mem_done;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic          ram_write_enable, ram_read_enable;
  logic [DW-1:0] ram_data_out;

  always #5 clk = ~clk;

  mem_interface #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk              (clk),
    .clear            (clear),
    .bus_in           (bus_in),
    .mar_in           (mar_in),
    .mdr_in           (mdr_in),
    .rd_req           (rd_req),
    .wr_req           (wr_req),
    .mdr_out          (mdr_out),
    .busy             (busy),
    .mem_done         (mem_done),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_write_enable (ram_write_enable),
    .ram_read_enable  (ram_read_enable),
    .ram_data_out     (ram_data_out)
  );

  // Synchronous RAM with registered read output
  logic [DW-1:0] ram_mem [0:255];
  initial for (int i = 0; i < 256; i++) ram_mem[i] = '0;
  always @(posedge clk) begin
    if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
    if (ram_read_enable)  ram_data_out <= ram_mem[ram_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level reference model
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  logic [DW-1:0] mem_m [0:255];
  logic [AW-1:0] mar_m;
  logic [DW-1:0] mdr_m;
  int            free_cyc;
  ev_t           wr_q[$];
  ev_t           rd_q[$];
  ev_t           done_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs (called just after a rising edge) and update the model.
  task automatic step(input logic m_in, input logic d_in, input logic [DW-1:0] bus,
                      input logic rd, input logic wr);
    ev_t e;
    mar_in = m_in;
    mdr_in = d_in;
    bus_in = bus;
    rd_req = rd;
    wr_req = wr;
    if (cyc >= free_cyc) begin
      if (m_in) mar_m = bus[AW-1:0];
      if (d_in) mdr_m = bus;
      if (wr) begin
        mem_m[mar_m] = mdr_m;
        e.addr = mar_m;
        e.data = mdr_m;
        e.cyc  = cyc + 1;
        wr_q.push_back(e);
        e.cyc  = cyc + 2;
        done_q.push_back(e);
        free_cyc = cyc + 3;
      end else if (rd) begin
        mdr_m  = mem_m[mar_m];
        e.addr = mar_m;
        e.data = mdr_m;
        e.cyc  = cyc + 1;
        rd_q.push_back(e);
        e.cyc  = cyc + 3;
        done_q.push_back(e);
        free_cyc = cyc + 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, $urandom, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    clear = 1'b1;
    repeat (n) begin
      mar_in = 1'($urandom); mdr_in = 1'($urandom); bus_in = $urandom;
      rd_req = 1'($urandom); wr_req = 1'($urandom);
      @(posedge clk);
      #1;
    end
    check("rst_mdr_out",     mdr_out, '0);
    check("rst_ram_address", {24'd0, ram_address}, '0);
    check("rst_ram_data_in", ram_data_in, '0);
    check("rst_busy",        {31'd0, busy}, '0);
    check("rst_mem_done",    {31'd0, mem_done}, '0);
    check("rst_enables",     {30'd0, ram_read_enable, ram_write_enable}, '0);
    clear = 1'b0; mar_in = 1'b0; mdr_in = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    wr_q.delete(); rd_q.delete(); done_q.delete();
    mar_m = '0; mdr_m = '0;
    free_cyc = cyc;
  endtask

  // Monitor: pops expected events whenever the DUT presents a strobe or done
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (clear) begin
      prev_done <= 1'b0;
    end else begin
      prev_done <= mem_done;
      if (ram_write_enable) begin
        check("wr_expected", {31'd0, wr_q.size() != 0}, 32'd1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_addr", {24'd0, ram_address}, {24'd0, e.addr});
          check("wr_data", ram_data_in, e.data);
        end
      end else if (wr_q.size() != 0 && cyc >= wr_q[0].cyc) begin
        check("wr_missing", cyc, wr_q[0].cyc - 1);
        void'(wr_q.pop_front());
      end
      if (ram_read_enable) begin
        check("rd_expected", {31'd0, rd_q.size() != 0}, 32'd1);
        if (rd_q.size() != 0) begin
          e = rd_q.pop_front();
          check("rd_cycle", cyc, e.cyc);
          check("rd_addr", {24'd0, ram_address}, {24'd0, e.addr});
        end
      end else if (rd_q.size() != 0 && cyc >= rd_q[0].cyc) begin
        check("rd_missing", cyc, rd_q[0].cyc - 1);
        void'(rd_q.pop_front());
      end
      if (mem_done) begin
        check("done_expected", {31'd0, done_q.size() != 0}, 32'd1);
        check("done_width", {31'd0, prev_done}, '0);
        check("done_busy", {31'd0, busy}, 32'd1);
        if (done_q.size() != 0) begin
          e = done_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("done_mdr", mdr_out, e.data);
        end
      end else if (done_q.size() != 0 && cyc >= done_q[0].cyc) begin
        check("done_missing", cyc, done_q[0].cyc - 1);
        void'(done_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] bus;
    logic [DW-1:0] saved;
    int            bad;
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
    clear = 1'b1; bus_in = '0; mar_in = 1'b0; mdr_in = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    free_cyc = 0;
    @(posedge clk);
    #1;
    do_reset(3);

    // Write 0xDEADBEEF to 0x12
    step(1'b1, 1'b0, 32'h0000_0012, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    idle(3);
    check("ram_0x12_after_write", ram_mem[8'h12], 32'hDEAD_BEEF);

    // Clear MDR, read 0x12 back
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0000_0012, 1'b1, 1'b0);
    idle(4);
    check("mdr_after_read", mdr_out, 32'hDEAD_BEEF);

    // Simultaneous read+write: write wins; upper bus bits ignored by MAR
    step(1'b1, 1'b0, 32'hFFFF_FF05, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_CAFE, 1'b1, 1'b1);
    idle(3);
    check("ram_0x05_simul", ram_mem[8'h05], 32'h0000_CAFE);

    // Busy lockout during a read of 0x12
    step(1'b1, 1'b0, 32'h0000_0012, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 32'h0000_0077, 1'b0, 1'b1);
    idle(2);
    check("lockout_mar", {24'd0, ram_address}, 32'h12);
    check("lockout_mdr", mdr_out, 32'hDEAD_BEEF);

    // Back-to-back writes with wr_req held
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(3);

    // Abort a write by asserting clear during WR_ISSUE
    saved = mem_m[8'h12];
    step(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b1);
    do_reset(2);
    mem_m[8'h12] = saved;
    @(posedge clk);
    #1;
    check("abort_no_write", ram_mem[8'h12], 32'hDEAD_BEEF);

    // Randomized traffic over a small address window
    repeat (800) begin
      bus = $urandom;
      if ($urandom_range(0, 3) != 0) bus[7:3] = '0;
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, bus,
           $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2);
    end
    idle(6);

    check("final_mar", {24'd0, ram_address}, {24'd0, mar_m});
    check("final_mdr", ram_data_in, mdr_m);
    check("queues_empty", wr_q.size() + rd_q.size() + done_q.size(), '0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram_mem[i] !== mem_m[i]) bad++;
    check("ram_contents", bad, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
